// File: rtl/arrival_time_averager_pkg.sv
// Shared types and constants for the arrival-time averaging path.
package arrival_time_averager_pkg;

  localparam int unsigned ArrivalW = 10;
  localparam int unsigned CountW   = 8;

  localparam logic [ArrivalW-1:0] TimeoutCodeDefault = 10'h3FF;

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StWait,
    StCheck,
    StUpdate
  } state_e;

  // Increment that sticks at all-ones.
  function automatic logic [CountW-1:0] sat_inc(input logic [CountW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/arrival_time_averager_window.sv
// Circular sample buffer with a running sum over the last 2^AvgLog2 accepted samples.
module avg_window
  import arrival_time_averager_pkg::*;
#(
  parameter int unsigned AvgLog2 = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        flush,
  input  logic                        wr_en,
  input  logic [ArrivalW-1:0]         din,
  output logic [ArrivalW+AvgLog2-1:0] sum,
  output logic                        full
);

  localparam int unsigned Depth = 1 << AvgLog2;
  localparam int unsigned SumW  = ArrivalW + AvgLog2;

  logic [ArrivalW-1:0] mem_q [Depth];
  logic [SumW-1:0]     sum_q, sum_d;
  logic [AvgLog2:0]    fill_q, fill_d;
  logic [AvgLog2-1:0]  ptr_q, ptr_d;
  logic [ArrivalW-1:0] evict;

  assign full = (fill_q == (AvgLog2 + 1)'(Depth));
  assign sum  = sum_q;

  // Next sum/fill/ptr: flush has priority; once full the overwritten sample leaves the sum.
  always_comb begin
    sum_d  = sum_q;
    fill_d = fill_q;
    ptr_d  = ptr_q;
    evict  = full ? mem_q[ptr_q] : '0;
    if (flush) begin
      sum_d  = '0;
      fill_d = '0;
      ptr_d  = '0;
    end else if (wr_en) begin
      sum_d  = sum_q + SumW'(din) - SumW'(evict);
      fill_d = full ? fill_q : fill_q + 1'b1;
      ptr_d  = ptr_q + 1'b1;  // Depth is a power of two, so this wraps naturally
    end
  end

  // Bookkeeping registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sum_q  <= '0;
      fill_q <= '0;
      ptr_q  <= '0;
    end else begin
      sum_q  <= sum_d;
      fill_q <= fill_d;
      ptr_q  <= ptr_d;
    end
  end

  // Sample storage; contents are only read once the window is full, so no reset needed.
  always_ff @(posedge clk_i) begin
    if (wr_en && !flush) begin
      mem_q[ptr_q] <= din;
    end
  end

endmodule

// File: rtl/arrival_time_averager.sv
// Per-burst arrival-time capture, timeout/outlier rejection and windowed averaging.
module arrival_time_averager
  import arrival_time_averager_pkg::*;
#(
  parameter int unsigned          AvgLog2      = 2,
  parameter int unsigned          RejectThresh = 40,
  parameter int unsigned          MaxRejects   = 3,
  parameter logic [ArrivalW-1:0]  TimeoutCode  = TimeoutCodeDefault
) (
  input  logic                SYS_CLK,
  input  logic                RSTn,
  input  logic                ON,
  input  logic                burstSent,
  input  logic [ArrivalW-1:0] ARRIVAL_TIME,
  input  logic                CLR_STATS,
  output logic [ArrivalW-1:0] AVG_TIME,
  output logic                AVG_VALID,
  output logic                AVG_STROBE,
  output logic [CountW-1:0]   MISS_COUNT,
  output logic [CountW-1:0]   REJECT_COUNT
);

  state_e                     state_q, state_d;
  logic                       burst_prev_q;
  logic                       burst_edge;
  logic [ArrivalW-1:0]        sample_q;
  logic                       accept_q;
  logic                       out_pend_q;
  logic [CountW-1:0]          consec_q, consec_inc;
  logic [CountW-1:0]          miss_q, rej_q;
  logic [ArrivalW-1:0]        avg_q;
  logic                       valid_q, strobe_q;
  logic signed [ArrivalW:0]   diff;
  logic [ArrivalW:0]          abs_diff;
  logic                       is_miss, is_outlier, reseed, accept, in_check;
  logic                       win_flush, win_wr, win_full;
  logic [ArrivalW+AvgLog2-1:0] win_sum;

  assign burst_edge = burstSent & ~burst_prev_q;
  assign in_check   = ON && (state_q == StCheck);

  // Sample classification during CHECK; difference is taken one bit wider so it cannot wrap.
  always_comb begin
    is_miss    = (sample_q == TimeoutCode);
    diff       = $signed({1'b0, sample_q}) - $signed({1'b0, avg_q});
    abs_diff   = diff[ArrivalW] ? (ArrivalW + 1)'(-diff) : (ArrivalW + 1)'(diff);
    is_outlier = !is_miss && valid_q && (32'(abs_diff) > RejectThresh);
    consec_inc = consec_q + 1'b1;
    reseed     = is_outlier && (32'(consec_inc) >= MaxRejects);
    accept     = !is_miss && (!is_outlier || reseed);
  end

  assign win_flush = !ON || (in_check && reseed);
  assign win_wr    = ON && (state_q == StUpdate) && accept_q;

  // Burst sequencing; dropping ON returns to IDLE from anywhere.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (ON) state_d = StArm;
      StArm:    if (burst_edge) state_d = StWait;  // first burst has no prior result
      StWait:   if (burst_edge) state_d = StCheck;
      StCheck:  state_d = StUpdate;
      StUpdate: state_d = StWait;
      default:  state_d = StIdle;
    endcase
    if (!ON) state_d = StIdle;
  end

  // State register and burst edge history.
  always_ff @(posedge SYS_CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q      <= StIdle;
      burst_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      burst_prev_q <= burstSent;
    end
  end

  // Capture the receiver result on the edge that starts a check.
  always_ff @(posedge SYS_CLK or negedge RSTn) begin
    if (!RSTn) begin
      sample_q <= '0;
    end else if (ON && (state_q == StWait) && burst_edge) begin
      sample_q <= ARRIVAL_TIME;
    end
  end

  // Accept decision and consecutive-reject tracking; misses leave the run length alone.
  always_ff @(posedge SYS_CLK or negedge RSTn) begin
    if (!RSTn) begin
      accept_q <= 1'b0;
      consec_q <= '0;
    end else if (!ON) begin
      accept_q <= 1'b0;
      consec_q <= '0;
    end else if (state_q == StCheck) begin
      accept_q <= accept;
      if (!is_miss) begin
        consec_q <= (is_outlier && !reseed) ? consec_inc : '0;
      end
    end
  end

  // Saturating statistics; a clear beats a simultaneous increment.
  always_ff @(posedge SYS_CLK or negedge RSTn) begin
    if (!RSTn) begin
      miss_q <= '0;
      rej_q  <= '0;
    end else if (CLR_STATS) begin
      miss_q <= '0;
      rej_q  <= '0;
    end else if (in_check) begin
      if (is_miss)    miss_q <= sat_inc(miss_q);
      if (is_outlier) rej_q  <= sat_inc(rej_q);
    end
  end

  // Registered average one cycle after the window write.
  always_ff @(posedge SYS_CLK or negedge RSTn) begin
    if (!RSTn) begin
      avg_q      <= '0;
      valid_q    <= 1'b0;
      strobe_q   <= 1'b0;
      out_pend_q <= 1'b0;
    end else if (!ON) begin
      avg_q      <= '0;
      valid_q    <= 1'b0;
      strobe_q   <= 1'b0;
      out_pend_q <= 1'b0;
    end else begin
      out_pend_q <= win_wr;
      strobe_q   <= 1'b0;
      if (in_check && reseed) begin
        valid_q <= 1'b0;
      end else if (out_pend_q && win_full) begin
        avg_q    <= ArrivalW'(win_sum >> AvgLog2);
        valid_q  <= 1'b1;
        strobe_q <= 1'b1;
      end
    end
  end

  avg_window #(
    .AvgLog2 (AvgLog2)
  ) u_window (
    .clk_i  (SYS_CLK),
    .rst_ni (RSTn),
    .flush  (win_flush),
    .wr_en  (win_wr),
    .din    (sample_q),
    .sum    (win_sum),
    .full   (win_full)
  );

  assign AVG_TIME     = avg_q;
  assign AVG_VALID    = valid_q;
  assign AVG_STROBE   = strobe_q;
  assign MISS_COUNT   = miss_q;
  assign REJECT_COUNT = rej_q;

endmodule

// File: tb/tb_arrival_time_averager.sv
// Directed bench for arrival_time_averager with default parameters.
module tb_arrival_time_averager;

  logic       SYS_CLK = 1'b0;
  logic       RSTn;
  logic       ON;
  logic       burstSent;
  logic [9:0] ARRIVAL_TIME;
  logic       CLR_STATS;
  logic [9:0] AVG_TIME;
  logic       AVG_VALID;
  logic       AVG_STROBE;
  logic [7:0] MISS_COUNT;
  logic [7:0] REJECT_COUNT;

  int checks   = 0;
  int failures = 0;

  logic [5:0] pat;
  logic [5:0] acc;

  // Strobe expected exactly at t+3 after the burst edge.
  localparam logic [5:0] StrobeAt3 = 6'b001000;
  localparam logic [5:0] NoStrobe  = 6'b000000;

  always #5 SYS_CLK = ~SYS_CLK;

  arrival_time_averager dut (
    .SYS_CLK      (SYS_CLK),
    .RSTn         (RSTn),
    .ON           (ON),
    .burstSent    (burstSent),
    .ARRIVAL_TIME (ARRIVAL_TIME),
    .CLR_STATS    (CLR_STATS),
    .AVG_TIME     (AVG_TIME),
    .AVG_VALID    (AVG_VALID),
    .AVG_STROBE   (AVG_STROBE),
    .MISS_COUNT   (MISS_COUNT),
    .REJECT_COUNT (REJECT_COUNT)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One burst: rising edge at posedge t, strobe recorded #1 after t..t+5.
  task automatic burst(input logic [9:0] v, output logic [5:0] p);
    @(negedge SYS_CLK);
    ARRIVAL_TIME = v;
    burstSent    = 1'b1;
    p = '0;
    for (int i = 0; i < 6; i++) begin
      @(posedge SYS_CLK);
      #1;
      p[i] = AVG_STROBE;
      if (i == 0) burstSent = 1'b0;
    end
  endtask

  initial begin
    RSTn = 1'b0; ON = 1'b0; burstSent = 1'b0; ARRIVAL_TIME = '0; CLR_STATS = 1'b0;
    repeat (3) @(posedge SYS_CLK);
    #1;
    check("rst_avg", AVG_TIME, 0);
    check("rst_valid", AVG_VALID, 0);
    check("rst_strobe", AVG_STROBE, 0);
    check("rst_miss", MISS_COUNT, 0);
    check("rst_rej", REJECT_COUNT, 0);
    @(negedge SYS_CLK);
    RSTn = 1'b1;
    @(negedge SYS_CLK);
    ON = 1'b1;

    // 1: first burst discarded, window full on the fifth
    burst(10'd100, pat); check("t1_b1_strobe", pat, NoStrobe);
    burst(10'd100, pat); check("t1_b2_strobe", pat, NoStrobe);
    burst(10'd100, pat); check("t1_b3_strobe", pat, NoStrobe);
    burst(10'd100, pat); check("t1_b4_strobe", pat, NoStrobe);
    check("t1_b4_valid", AVG_VALID, 0);
    burst(10'd100, pat); check("t1_b5_strobe", pat, StrobeAt3);
    check("t1_avg", AVG_TIME, 100);
    check("t1_valid", AVG_VALID, 1);

    // 2: sliding window 100,104,108,112 -> 106, then 116 -> 110
    burst(10'd104, pat); check("t2_104_avg", AVG_TIME, 101);
    burst(10'd108, pat); check("t2_108_avg", AVG_TIME, 103);
    burst(10'd112, pat); check("t2_112_strobe", pat, StrobeAt3);
    check("t2_112_avg", AVG_TIME, 106);
    burst(10'd116, pat); check("t2_116_strobe", pat, StrobeAt3);
    check("t2_116_avg", AVG_TIME, 110);

    // Full-window flush via ON
    @(negedge SYS_CLK); ON = 1'b0;
    @(negedge SYS_CLK);
    check("on_low_avg", AVG_TIME, 0);
    check("on_low_valid", AVG_VALID, 0);
    ON = 1'b1;

    // 3: steady 200, single outlier rejected, run length reset by a good sample
    burst(10'd200, pat); check("t3_discard_strobe", pat, NoStrobe);
    for (int i = 0; i < 3; i++) burst(10'd200, pat);
    burst(10'd200, pat); check("t3_full_strobe", pat, StrobeAt3);
    check("t3_avg", AVG_TIME, 200);
    burst(10'd300, pat); check("t3_rej_strobe", pat, NoStrobe);
    check("t3_rej_cnt", REJECT_COUNT, 1);
    check("t3_rej_avg", AVG_TIME, 200);
    burst(10'd200, pat); check("t3_acc_strobe", pat, StrobeAt3);
    burst(10'd300, pat);
    burst(10'd300, pat);
    burst(10'd200, pat); check("t3_consec_reset_strobe", pat, StrobeAt3);
    check("t3_consec_valid", AVG_VALID, 1);
    check("t3_rej_cnt3", REJECT_COUNT, 3);

    // 4: three consecutive outliers force a re-seed
    burst(10'd300, pat);
    burst(10'd300, pat);
    check("t4_pre_valid", AVG_VALID, 1);
    burst(10'd300, pat); check("t4_reseed_strobe", pat, NoStrobe);
    check("t4_reseed_valid", AVG_VALID, 0);
    check("t4_reseed_avg", AVG_TIME, 200);
    check("t4_rej_cnt", REJECT_COUNT, 6);
    burst(10'd300, pat);
    burst(10'd300, pat); check("t4_fill3_strobe", pat, NoStrobe);
    burst(10'd300, pat); check("t4_fill4_strobe", pat, StrobeAt3);
    check("t4_avg", AVG_TIME, 300);
    check("t4_valid", AVG_VALID, 1);

    // 5: timeout saturation, then clear
    acc = '0;
    for (int i = 0; i < 260; i++) begin
      burst(10'h3FF, pat);
      acc = acc | pat;
    end
    check("t5_miss_sat", MISS_COUNT, 255);
    check("t5_no_strobe", acc, NoStrobe);
    check("t5_avg", AVG_TIME, 300);
    check("t5_rej_kept", REJECT_COUNT, 6);
    @(negedge SYS_CLK); CLR_STATS = 1'b1;
    @(negedge SYS_CLK); CLR_STATS = 1'b0;
    check("t5_clr_miss", MISS_COUNT, 0);
    check("t5_clr_rej", REJECT_COUNT, 0);
    burst(10'h3FF, pat); check("t5_miss_after_clr", MISS_COUNT, 1);

    // 6a: reset asserted while a sample is in UPDATE
    @(negedge SYS_CLK);
    ARRIVAL_TIME = 10'd300;
    burstSent    = 1'b1;
    @(posedge SYS_CLK);
    @(posedge SYS_CLK);
    #1 RSTn = 1'b0;
    #1;
    check("t6_rst_avg", AVG_TIME, 0);
    check("t6_rst_valid", AVG_VALID, 0);
    check("t6_rst_strobe", AVG_STROBE, 0);
    check("t6_rst_miss", MISS_COUNT, 0);
    @(negedge SYS_CLK);
    burstSent = 1'b0;
    @(negedge SYS_CLK);
    RSTn = 1'b1;
    burst(10'd300, pat); check("t6_rearm_discard", pat, NoStrobe);
    burst(10'd300, pat);
    burst(10'd300, pat);

    // 6b: ON dropped with a half-filled window
    @(negedge SYS_CLK); ON = 1'b0;
    @(negedge SYS_CLK); ON = 1'b1;
    check("t6_on_valid", AVG_VALID, 0);
    burst(10'd300, pat); check("t6_on_discard", pat, NoStrobe);
    burst(10'd300, pat);
    burst(10'd300, pat); check("t6_on_fill2", pat, NoStrobe);
    burst(10'd300, pat); check("t6_on_fill3", pat, NoStrobe);
    burst(10'd300, pat); check("t6_on_fill4", pat, StrobeAt3);
    check("t6_on_avg", AVG_TIME, 300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
